// File: rtl/cp_id.sv
// cp_id: instruction decode stage of the CP pipeline.
// Resolves operands through the bypass network and evaluates predication
// and branches. The branch target and taken flag go back to fetch
// combinationally. The decoded instruction is registered into the ID/EX
// pipeline register.
module cp_id #(
  parameter int ADDR_W   = 8,
  parameter int INS_W    = 24,
  parameter int DATA_W   = 32,
  parameter int RF_IDX_W = 5,
  parameter int LINK_REG = 9
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic [ADDR_W-1:0]   iIF_ID_PC,
  input  logic [INS_W-1:0]    iIF_ID_Instruction,
  input  logic [2:0]          iIF_ID_Branch_Op,
  input  logic                iIF_BP_Select_Imm,
  input  logic                iIF_BP_Bypass_Read_A,
  input  logic                iIF_BP_Bypass_Read_B,
  input  logic [1:0]          iIF_BP_Bypass_Sel_A,
  input  logic [1:0]          iIF_BP_Bypass_Sel_B,
  input  logic [1:0]          iPredication,
  input  logic                iSelect_First_PE,
  input  logic                iSelect_Last_PE,
  input  logic [DATA_W-1:0]   iRF_Read_Data_A,
  input  logic [DATA_W-1:0]   iRF_Read_Data_B,
  input  logic [DATA_W-1:0]   iEX_Result,
  input  logic [DATA_W-1:0]   iWB_Result,
  input  logic [DATA_W-1:0]   iFirst_PE_Data,
  input  logic [DATA_W-1:0]   iLast_PE_Data,
  input  logic                iEX_Flag_Write,
  input  logic                iEX_Flag_Value,
  output logic [ADDR_W-1:0]   oID_IF_Branch_Target_Addr,
  output logic                oID_IF_Branch_Taken_Flag,
  output logic                oID_EX_Valid,
  output logic [ADDR_W-1:0]   oID_EX_PC,
  output logic [INS_W-1:0]    oID_EX_Instruction,
  output logic [DATA_W-1:0]   oID_EX_Operand_A,
  output logic [DATA_W-1:0]   oID_EX_Operand_B,
  output logic                oID_EX_Link_En,
  output logic [RF_IDX_W-1:0] oID_EX_Link_Reg,
  output logic [ADDR_W-1:0]   oID_EX_Link_Value,
  output logic                oFlag
);

  localparam logic [2:0] BR_NOP  = 3'b000;
  localparam logic [2:0] BR_J    = 3'b001;
  localparam logic [2:0] BR_JAL  = 3'b010;
  localparam logic [2:0] BR_JR   = 3'b011;
  localparam logic [2:0] BR_JALR = 3'b100;
  localparam logic [2:0] BR_BF   = 3'b101;
  localparam logic [2:0] BR_BNF  = 3'b110;

  localparam logic [RF_IDX_W-1:0] LINK_IDX = RF_IDX_W'(LINK_REG);

  logic                r_flag;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_pc;
  logic [INS_W-1:0]    r_ins;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic                r_link_en;
  logic [RF_IDX_W-1:0] r_link_reg;
  logic [ADDR_W-1:0]   r_link_val;

  logic [DATA_W-1:0]   w_pe_data;
  logic [DATA_W-1:0]   w_src_a;
  logic [DATA_W-1:0]   w_src_b;
  logic [DATA_W-1:0]   w_op_a;
  logic [DATA_W-1:0]   w_op_b;
  logic [DATA_W-1:0]   w_imm;
  logic [ADDR_W+15:0]  w_off_ext;
  logic [ADDR_W-1:0]   w_offset;
  logic                w_feff;
  logic                w_exec;
  logic                w_taken;
  logic                w_use_reg;
  logic                w_link;
  logic [ADDR_W-1:0]   w_target;

  // The sign extension is wider than needed and the low ADDR_W bits are kept.
  // This way one expression covers both a narrow PC (offset truncated) and a
  // wide PC (offset sign-extended).
  assign w_off_ext = {{ADDR_W{iIF_ID_Instruction[15]}}, iIF_ID_Instruction[15:0]};
  assign w_offset  = w_off_ext[ADDR_W-1:0];
  assign w_imm     = {{(DATA_W-12){iIF_ID_Instruction[11]}}, iIF_ID_Instruction[11:0]};

  // PE boundary data: first PE wins when both selects are set.
  always_comb begin
    w_pe_data = {DATA_W{1'b0}};
    if (iSelect_First_PE) begin
      w_pe_data = iFirst_PE_Data;
    end else if (iSelect_Last_PE) begin
      w_pe_data = iLast_PE_Data;
    end else begin
      w_pe_data = {DATA_W{1'b0}};
    end
  end

  // Bypass source multiplexers for operands A and B.
  always_comb begin
    w_src_a = {DATA_W{1'b0}};
    w_src_b = {DATA_W{1'b0}};
    case (iIF_BP_Bypass_Sel_A)
      2'b00:   w_src_a = iEX_Result;
      2'b01:   w_src_a = iWB_Result;
      2'b10:   w_src_a = w_pe_data;
      default: w_src_a = {DATA_W{1'b0}};
    endcase
    case (iIF_BP_Bypass_Sel_B)
      2'b00:   w_src_b = iEX_Result;
      2'b01:   w_src_b = iWB_Result;
      2'b10:   w_src_b = w_pe_data;
      default: w_src_b = {DATA_W{1'b0}};
    endcase
  end

  // Final operands: bypass or RF for A, and for B the immediate overrides both.
  always_comb begin
    w_op_a = iIF_BP_Bypass_Read_A ? w_src_a : iRF_Read_Data_A;
    if (iIF_BP_Select_Imm) begin
      w_op_b = w_imm;
    end else if (iIF_BP_Bypass_Read_B) begin
      w_op_b = w_src_b;
    end else begin
      w_op_b = iRF_Read_Data_B;
    end
  end

  // Effective flag and predicate. The older EX instruction's flag update is
  // forwarded, so it takes precedence over the architectural flag.
  always_comb begin
    w_feff = iEX_Flag_Write ? iEX_Flag_Value : r_flag;
    w_exec = 1'b0;
    case (iPredication)
      2'b00:   w_exec = 1'b1;
      2'b01:   w_exec = w_feff;
      2'b10:   w_exec = ~w_feff;
      default: w_exec = 1'b0;
    endcase
  end

  // Branch decode. The target is driven even when the instruction is predicated off.
  always_comb begin
    w_taken   = 1'b0;
    w_use_reg = 1'b0;
    w_link    = 1'b0;
    case (iIF_ID_Branch_Op)
      BR_NOP:  w_taken = 1'b0;
      BR_J:    w_taken = 1'b1;
      BR_JAL:  begin w_taken = 1'b1; w_link = 1'b1; end
      BR_JR:   begin w_taken = 1'b1; w_use_reg = 1'b1; end
      BR_JALR: begin w_taken = 1'b1; w_use_reg = 1'b1; w_link = 1'b1; end
      BR_BF:   w_taken = w_feff;
      BR_BNF:  w_taken = ~w_feff;
      default: w_taken = 1'b0;
    endcase
    w_target = w_use_reg ? w_op_a[ADDR_W-1:0] : (iIF_ID_PC + w_offset);
  end

  assign oID_IF_Branch_Target_Addr = w_target;
  assign oID_IF_Branch_Taken_Flag  = w_exec & w_taken;

  // Architectural compare flag, updated by EX.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_flag <= 1'b0;
    end else if (iEX_Flag_Write) begin
      r_flag <= iEX_Flag_Value;
    end else begin
      r_flag <= r_flag;
    end
  end

  // ID/EX pipeline register. It loads every cycle because there is no stall.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_valid    <= 1'b0;
      r_pc       <= {ADDR_W{1'b0}};
      r_ins      <= {INS_W{1'b0}};
      r_op_a     <= {DATA_W{1'b0}};
      r_op_b     <= {DATA_W{1'b0}};
      r_link_en  <= 1'b0;
      r_link_reg <= {RF_IDX_W{1'b0}};
      r_link_val <= {ADDR_W{1'b0}};
    end else begin
      r_valid    <= w_exec;
      r_pc       <= iIF_ID_PC;
      r_ins      <= iIF_ID_Instruction;
      r_op_a     <= w_op_a;
      r_op_b     <= w_op_b;
      r_link_en  <= w_exec & w_link;
      r_link_reg <= (w_exec & w_link) ? LINK_IDX : {RF_IDX_W{1'b0}};
      // The return address skips the delay slot.
      r_link_val <= iIF_ID_PC + ADDR_W'(2);
    end
  end

  assign oID_EX_Valid       = r_valid;
  assign oID_EX_PC          = r_pc;
  assign oID_EX_Instruction = r_ins;
  assign oID_EX_Operand_A   = r_op_a;
  assign oID_EX_Operand_B   = r_op_b;
  assign oID_EX_Link_En     = r_link_en;
  assign oID_EX_Link_Reg    = r_link_reg;
  assign oID_EX_Link_Value  = r_link_val;
  assign oFlag              = r_flag;

endmodule
